// File: rtl/apb_pkg.sv
// Shared APB master types and default parameters.
// The state enum and the watchdog width helper are used by apb_master and apb_wdog.
package apb_pkg;

   localparam int unsigned DEF_DWIDTH  = 8;
   localparam int unsigned DEF_AWIDTH  = 8;
   localparam int unsigned DEF_TIMEOUT = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // Wide enough to hold TIMEOUT itself; a disabled watchdog keeps one bit.
   function automatic int unsigned wdog_width(input int unsigned timeout);
      return (timeout == 0) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/apb_wdog.sv
// ACCESS-phase wait counter: cleared in SETUP, counts stalled ACCESS cycles.
// expired flags the stalled cycle that brings the count to TIMEOUT (never when TIMEOUT is 0).
module apb_wdog
   import apb_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = wdog_width(TIMEOUT);
   localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT);
   localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          at_last;

   always_comb begin
      at_last = 1'b0;
      if (TIMEOUT != 0) begin
         at_last = (cnt_q == LIMIT_M1);
      end
      expired = enable && at_last;

      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (TIMEOUT != 0) && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: command handshake in, IDLE/SETUP/ACCESS sequencing, one-cycle response pulse out.
// Every output is a flop; APB inputs only steer next-state logic.
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned DWIDTH  = DEF_DWIDTH,
   parameter int unsigned AWIDTH  = DEF_AWIDTH,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [AWIDTH-1:0] cmd_addr,
   input  logic [DWIDTH-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DWIDTH-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [AWIDTH-1:0] PADDR,
   output logic [DWIDTH-1:0] PWDATA,
   input  logic [DWIDTH-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   apb_state_e        state_q, state_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [AWIDTH-1:0] paddr_q, paddr_d;
   logic [DWIDTH-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   logic wdog_clear, wdog_enable, wdog_expired;

   apb_wdog #(
      .TIMEOUT(TIMEOUT)
   ) u_wdog (
      .clk     (PCLK),
      .rst     (PRESET),
      .clear   (wdog_clear),
      .enable  (wdog_enable),
      .expired (wdog_expired)
   );

   always_comb begin
      state_d     = state_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      wdog_clear  = (state_q == SETUP);
      wdog_enable = (state_q == ACCESS) && !PREADY;

      case (state_q)
         IDLE: begin
            // The address/control flops double as the command latch, so they hold through IDLE.
            if (cmd_valid && cmd_ready_q) begin
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = PSLVERR;
               rsp_rdata_d = (pwrite_q || PSLVERR) ? '0 : PRDATA;
            end else if (wdog_expired) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered copies of what the next state implies.
      cmd_ready_d = (state_d == IDLE);
      psel_d      = (state_d != IDLE);
      penable_d   = (state_d == ACCESS);
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: driver pushes expected transfers, slave model answers on APB,
// monitor pops and checks each response and the APB phase sequence.
module tb_apb_master;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 8;
   localparam int unsigned TO = 16;

   logic          PCLK      = 1'b0;
   logic          PRESET    = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr  = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [DW-1:0] PRDATA    = '0;
   logic          PREADY    = 1'b0;
   logic          PSLVERR   = 1'b0;
   logic          cmd_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE;
   logic [DW-1:0] rsp_rdata, PWDATA;
   logic [AW-1:0] PADDR;

   always #5 PCLK = ~PCLK;

   apb_master #(
      .DWIDTH  (DW),
      .AWIDTH  (AW),
      .TIMEOUT (TO)
   ) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   typedef struct {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int unsigned   waits;
      logic          perr;
      logic [DW-1:0] prdata;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
      int unsigned   exp_access;
   } txn_t;

   txn_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: slave holds PREADY low for 'waits' ACCESS cycles; the master gives up after TO stalled cycles.
   function automatic txn_t make_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                     input int unsigned waits, input logic perr, input logic [DW-1:0] rd);
      txn_t t;
      bit   timed_out;
      timed_out    = (waits >= TO);
      t.write      = w;
      t.addr       = a;
      t.wdata      = wd;
      t.waits      = waits;
      t.perr       = perr;
      t.prdata     = rd;
      t.exp_access = timed_out ? TO : waits + 1;
      t.exp_err    = timed_out ? 1'b1 : perr;
      t.exp_rdata  = (timed_out || w || perr) ? '0 : rd;
      return t;
   endfunction

   // Slave: answers the transfer at the queue head; drives junk outside the answering cycle.
   int unsigned slave_cnt = 0;
   always @(negedge PCLK) begin
      if (PSEL && PENABLE && exp_q.size() > 0 && slave_cnt == exp_q[0].waits) begin
         PREADY  = 1'b1;
         PSLVERR = exp_q[0].perr;
         PRDATA  = exp_q[0].prdata;
      end else begin
         PREADY  = (PSEL && PENABLE) ? 1'b0 : 1'($urandom);
         PSLVERR = 1'($urandom);
         PRDATA  = DW'($urandom);
      end
      slave_cnt = (PSEL && PENABLE) ? slave_cnt + 1 : 0;
   end

   // Monitor
   int            setup_cnt   = 0;
   int            access_cnt  = 0;
   bit            prev_access = 1'b0;
   logic [DW-1:0] last_rdata  = '0;
   logic          last_err    = 1'b0;
   txn_t          mon_t;

   always begin
      @(negedge PCLK);
      #1;
      if (PRESET) begin
         setup_cnt   = 0;
         access_cnt  = 0;
         prev_access = 1'b0;
         last_rdata  = '0;
         last_err    = 1'b0;
      end else begin
         if (PSEL && !PENABLE) begin
            setup_cnt++;
            chk("setup_cmd_ready", cmd_ready, 0);
            if (exp_q.size() > 0) begin
               chk("setup_paddr", PADDR, exp_q[0].addr);
               chk("setup_pwrite", PWRITE, exp_q[0].write);
               chk("setup_pwdata", PWDATA, exp_q[0].wdata);
            end
         end
         if (PSEL && PENABLE) begin
            access_cnt++;
            chk("access_cmd_ready", cmd_ready, 0);
            if (exp_q.size() > 0) begin
               chk("access_paddr_stable", PADDR, exp_q[0].addr);
               chk("access_pwrite_stable", PWRITE, exp_q[0].write);
               chk("access_pwdata_stable", PWDATA, exp_q[0].wdata);
            end
         end
         if (!PSEL) chk("idle_penable", PENABLE, 0);
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", rsp_valid, 0);
            end else begin
               mon_t = exp_q.pop_front();
               chk("rsp_rdata", rsp_rdata, mon_t.exp_rdata);
               chk("rsp_err", rsp_err, mon_t.exp_err);
               chk("access_cycles", access_cnt, mon_t.exp_access);
               chk("setup_cycles", setup_cnt, 1);
               chk("rsp_after_access", prev_access, 1);
               chk("rsp_cmd_ready", cmd_ready, 1);
               chk("rsp_psel", PSEL, 0);
            end
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            setup_cnt  = 0;
            access_cnt = 0;
         end else begin
            chk("rsp_rdata_hold", rsp_rdata, last_rdata);
            chk("rsp_err_hold", rsp_err, last_err);
         end
         prev_access = PSEL && PENABLE;
      end
   end

   // Called at a negedge; returns at the negedge of the response cycle with cmd_valid low.
   task automatic issue(input txn_t t, input bit junk, output int unsigned acc_wait);
      int unsigned budget;
      exp_q.push_back(t);
      cmd_valid = 1'b1;
      cmd_write = t.write;
      cmd_addr  = t.addr;
      cmd_wdata = t.wdata;
      budget = 0;
      while (!cmd_ready && budget < 50) begin
         @(negedge PCLK);
         budget++;
      end
      acc_wait = budget;
      chk("accept_bound", cmd_ready, 1);
      @(posedge PCLK);
      @(negedge PCLK);
      budget = 0;
      while (!cmd_ready && budget < 60) begin
         if (junk) begin
            cmd_valid = 1'b1;
            cmd_write = 1'($urandom);
            cmd_addr  = AW'($urandom);
            cmd_wdata = DW'($urandom);
         end else begin
            cmd_valid = 1'b0;
         end
         @(negedge PCLK);
         budget++;
      end
      chk("complete_bound", cmd_ready, 1);
      cmd_valid = 1'b0;
   endtask

   task automatic abort_in_access();
      int unsigned budget;
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 8'h33;
      cmd_wdata = 8'h00;
      budget = 0;
      while (!cmd_ready && budget < 50) begin
         @(negedge PCLK);
         budget++;
      end
      @(posedge PCLK);
      @(negedge PCLK);
      cmd_valid = 1'b0;
      budget = 0;
      while (!(PSEL && PENABLE) && budget < 10) begin
         @(negedge PCLK);
         budget++;
      end
      chk("abort_reached_access", PENABLE, 1);
      repeat (2) @(negedge PCLK);
      PRESET = 1'b1;
      @(posedge PCLK);
      #1;
      chk("abort_psel", PSEL, 0);
      chk("abort_penable", PENABLE, 0);
      chk("abort_cmd_ready", cmd_ready, 0);
      chk("abort_rsp_valid", rsp_valid, 0);
      @(negedge PCLK);
      @(negedge PCLK);
      PRESET = 1'b0;
      @(posedge PCLK);
      #1;
      chk("abort_release_cmd_ready", cmd_ready, 1);
      chk("abort_release_psel", PSEL, 0);
      @(negedge PCLK);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      int unsigned aw;
      txn_t        t;

      repeat (3) @(posedge PCLK);
      #1;
      chk("reset_cmd_ready", cmd_ready, 0);
      chk("reset_psel", PSEL, 0);
      chk("reset_penable", PENABLE, 0);
      chk("reset_pwrite", PWRITE, 0);
      chk("reset_paddr", PADDR, 0);
      chk("reset_pwdata", PWDATA, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_rdata", rsp_rdata, 0);
      chk("reset_rsp_err", rsp_err, 0);
      @(negedge PCLK);
      PRESET = 1'b0;
      @(posedge PCLK);
      #1;
      chk("release_cmd_ready", cmd_ready, 1);
      @(negedge PCLK);

      issue(make_txn(1'b1, 8'h02, 8'hA5, 0, 1'b0, 8'h00), 1'b0, aw);
      repeat (2) @(negedge PCLK);
      issue(make_txn(1'b0, 8'h01, 8'h00, 3, 1'b0, 8'h3C), 1'b0, aw);
      issue(make_txn(1'b0, 8'h40, 8'h11, 40, 1'b0, 8'hEE), 1'b0, aw);
      issue(make_txn(1'b0, 8'h41, 8'h22, TO - 1, 1'b0, 8'h77), 1'b0, aw);
      issue(make_txn(1'b0, 8'h42, 8'h33, TO, 1'b0, 8'h88), 1'b0, aw);
      issue(make_txn(1'b1, 8'h10, 8'h5A, 2, 1'b1, 8'hFF), 1'b0, aw);
      issue(make_txn(1'b0, 8'h11, 8'h00, 0, 1'b0, 8'h99), 1'b0, aw);
      chk("back_to_back_accept_wait", aw, 0);
      issue(make_txn(1'b0, 8'h12, 8'h00, 1, 1'b1, 8'h44), 1'b0, aw);
      issue(make_txn(1'b0, 8'h20, 8'h00, 4, 1'b0, 8'hC3), 1'b1, aw);
      issue(make_txn(1'b1, 8'h21, 8'h6B, 2, 1'b0, 8'h12), 1'b1, aw);
      repeat (2) @(negedge PCLK);

      abort_in_access();
      issue(make_txn(1'b0, 8'h50, 8'h00, 1, 1'b0, 8'h5E), 1'b0, aw);

      for (int i = 0; i < 150; i++) begin
         t = make_txn(1'($urandom), AW'($urandom), DW'($urandom),
                      ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 4) : $urandom_range(0, 4),
                      ($urandom_range(0, 3) == 0), DW'($urandom));
         issue(t, 1'($urandom), aw);
         repeat ($urandom_range(0, 2)) @(negedge PCLK);
      end

      repeat (4) @(negedge PCLK);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter DWIDTH, default 8, data width of PWDATA/PRDATA/cmd_wdata/rsp_rdata.
REQ-002 Parameter AWIDTH, default 8, address width of PADDR/cmd_addr.
REQ-003 Parameter TIMEOUT, default 16, max ACCESS-phase wait cycles; 0 disables timeout.
REQ-004 PCLK  input  1  the single clock; all logic SHALL be rising-edge PCLK.
REQ-005 PRESET  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at PCLK edge.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  AWIDTH  transfer address.
REQ-010 cmd_wdata  input  DWIDTH  write data.
REQ-011 rsp_valid  output  1  one-cycle pulse, transfer complete.
REQ-012 rsp_rdata  output  DWIDTH  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  PSLVERR seen or timeout; qualified by rsp_valid.
REQ-014 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-015 PADDR  output  AWIDTH; PWDATA  output  DWIDTH.
REQ-016 PRDATA  input  DWIDTH; PREADY  input  1; PSLVERR  input  1.

Function
REQ-017 FSM states IDLE, SETUP, ACCESS; the block SHALL handle one transfer at a time.
REQ-018 IDLE: cmd_ready=1, PSEL=0, PENABLE=0; on accept, latch cmd_write/addr/wdata, go SETUP.
REQ-019 SETUP (exactly one cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = latched values; go ACCESS.
REQ-020 ACCESS: PSEL=1, PENABLE=1; stay while PREADY=0 and timeout not reached.
REQ-021 ACCESS with PREADY=1: capture PRDATA (read only) and PSLVERR, go IDLE; rsp_valid=1 next cycle.
REQ-022 Latency with zero-wait slave: accept edge N, SETUP N+1, ACCESS N+2, rsp_valid and cmd_ready N+3.
REQ-023 cmd_ready SHALL be 0 in SETUP and ACCESS; cmd_valid there is ignored, not latched.
REQ-024 PADDR, PWRITE, PWDATA SHALL be stable from SETUP through final ACCESS cycle and hold value in IDLE until next accept.
REQ-025 Wait counter SHALL clear on SETUP, increment each ACCESS cycle with PREADY=0.
REQ-026 If counter reaches TIMEOUT while PREADY=0: end transfer, go IDLE, rsp_err=1, rsp_rdata=0.
REQ-027 PREADY=1 in same cycle as timeout hit: PREADY wins, normal completion.
REQ-028 Write completion: rsp_rdata=0, rsp_err=PSLVERR.
REQ-029 rsp_rdata/rsp_err SHALL hold until next rsp_valid.
REQ-030 PREADY/PSLVERR/PRDATA SHALL be ignored outside ACCESS.

Reset
REQ-031 PRESET=1 at edge: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
REQ-032 cmd_ready SHALL be 0 while PRESET=1, 1 on first cycle after release.
REQ-033 Reset during SETUP/ACCESS aborts transfer; no rsp_valid generated for it.

Structure
REQ-034 Package apb_pkg SHALL hold state enum (IDLE/SETUP/ACCESS) and default DWIDTH/AWIDTH/TIMEOUT constants.
REQ-035 One sub-module apb_wdog: wait counter, ports clear/enable/expired, width clog2(TIMEOUT+1).
REQ-036 All outputs registered; no combinational path from APB inputs to APB outputs.

Verification
REQ-037 Write addr 0x02 data 0xA5, PREADY tied 1 -> PSEL N+1..N+2, PENABLE N+2, PWDATA=0xA5, rsp_valid N+3, rsp_err=0.
REQ-038 Read addr 0x01, slave PRDATA=0x3C, PREADY low 3 ACCESS cycles -> ACCESS lasts 4 cycles, rsp_rdata=0x3C.
REQ-039 Read, PREADY never 1, TIMEOUT=16 -> exit after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0.
REQ-040 Write with PSLVERR=1 at PREADY -> rsp_err=1; next command back-to-back accepted at rsp_valid cycle.
REQ-041 PRESET asserted in ACCESS -> PSEL=PENABLE=0 next edge, no rsp_valid, cmd_ready=1 after release.
REQ-042 cmd_valid held high during transfer with changing cmd_addr -> PADDR unchanged until completion.
